// File: rtl/multi_mode_ff_bank_if.sv
// Stimulus/state bundle for multi_mode_ff_bank; err_cnt exists only when FF_BANK_ERRCNT_EN is defined.
interface multi_mode_ff_bank_if #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 8
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             err_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic             invalid;
  logic             err_sticky;
`ifdef FF_BANK_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_cnt;
`endif

  modport master (
    output en, mode, a, b, err_clr,
    input  q, qn, invalid, err_sticky
`ifdef FF_BANK_ERRCNT_EN
    , input err_cnt
`endif
  );

  modport slave (
    input  en, mode, a, b, err_clr,
    output q, qn, invalid, err_sticky
`ifdef FF_BANK_ERRCNT_EN
    , output err_cnt
`endif
  );
endinterface

// File: rtl/multi_mode_ff_bank.sv
// WIDTH-channel SR/JK/D/T flip-flop bank with shared mode, enable and SR 1/1 error tracking.
// Optional saturating invalid-event counter enabled by FF_BANK_ERRCNT_EN.
module multi_mode_ff_bank #(
  parameter int WIDTH       = 8,
  parameter int SR11_POLICY = 0,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  multi_mode_ff_bank_if.slave  bus
);
  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_sr_both;
  logic [WIDTH-1:0] w_sr_base;
  logic [WIDTH-1:0] w_sr_nxt;
  logic             w_invalid_evt;
  logic             r_invalid;
  logic             r_err_sticky;

  always_comb begin
    w_sr_both = bus.a & bus.b;
    // S-only sets, R-only clears; S=R=1 falls through as hold before the policy is applied.
    w_sr_base = (r_q | (bus.a & ~bus.b)) & ~(~bus.a & bus.b);
    case (SR11_POLICY)
      1:       w_sr_nxt = w_sr_base | w_sr_both;
      2:       w_sr_nxt = w_sr_base & ~w_sr_both;
      3:       w_sr_nxt = w_sr_base ^ w_sr_both;
      default: w_sr_nxt = w_sr_base;
    endcase
  end

  always_comb begin
    w_q_nxt = r_q;
    if (bus.en) begin
      case (bus.mode)
        MODE_SR: w_q_nxt = w_sr_nxt;
        MODE_JK: w_q_nxt = (bus.a & ~r_q) | (~bus.b & r_q);
        MODE_D:  w_q_nxt = bus.a;
        MODE_T:  w_q_nxt = r_q ^ bus.a;
        default: w_q_nxt = r_q;
      endcase
    end
  end

  assign w_invalid_evt = bus.en && (bus.mode == MODE_SR) && (|w_sr_both);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q          <= '0;
      r_invalid    <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_q       <= w_q_nxt;
      r_invalid <= w_invalid_evt;
      // A new event outranks a clear arriving on the same edge.
      if (w_invalid_evt) begin
        r_err_sticky <= 1'b1;
      end else if (bus.err_clr) begin
        r_err_sticky <= 1'b0;
      end
    end
  end

`ifdef FF_BANK_ERRCNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_cnt <= '0;
    end else if (bus.err_clr) begin
      r_err_cnt <= w_invalid_evt ? ERR_CNT_W'(1) : '0;
    end else if (w_invalid_evt && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

  assign bus.err_cnt = r_err_cnt;
`endif

  assign bus.q          = r_q;
  assign bus.qn         = ~r_q;
  assign bus.invalid    = r_invalid;
  assign bus.err_sticky = r_err_sticky;
endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Directed bench: three banks (SR11 policy 0, 1, 3) driven by the same stimulus.
module tb_multi_mode_ff_bank;
  localparam int W = 8;
  localparam logic [1:0] SR = 2'b00, JK = 2'b01, DM = 2'b10, TM = 2'b11;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [W-1:0] a, b;
  logic       err_clr;

  int n_total = 0;
  int n_bad   = 0;

  multi_mode_ff_bank_if #(.WIDTH(W), .ERR_CNT_W(2)) if0 ();
  multi_mode_ff_bank_if #(.WIDTH(W), .ERR_CNT_W(2)) if1 ();
  multi_mode_ff_bank_if #(.WIDTH(W), .ERR_CNT_W(2)) if3 ();

  assign if0.en = en;  assign if0.mode = mode;  assign if0.a = a;  assign if0.b = b;  assign if0.err_clr = err_clr;
  assign if1.en = en;  assign if1.mode = mode;  assign if1.a = a;  assign if1.b = b;  assign if1.err_clr = err_clr;
  assign if3.en = en;  assign if3.mode = mode;  assign if3.a = a;  assign if3.b = b;  assign if3.err_clr = err_clr;

  multi_mode_ff_bank #(.WIDTH(W), .SR11_POLICY(0), .ERR_CNT_W(2)) u_p0 (.clk(clk), .rst(rst), .bus(if0));
  multi_mode_ff_bank #(.WIDTH(W), .SR11_POLICY(1), .ERR_CNT_W(2)) u_p1 (.clk(clk), .rst(rst), .bus(if1));
  multi_mode_ff_bank #(.WIDTH(W), .SR11_POLICY(3), .ERR_CNT_W(2)) u_p3 (.clk(clk), .rst(rst), .bus(if3));

  // Clock held idle at first so reset can be observed with no edge.
  initial begin
    clk = 1'b0;
    #10;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [1:0] m, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic c);
    en = e; mode = m; a = av; b = bv; err_clr = c;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, SR, 8'h00, 8'h00, 1'b0);

    // 1. asynchronous reset with idle clock
    #3 rst = 1'b0;
    #1;
    chk("rst_q",      32'(if0.q),          32'h00);
    chk("rst_qn",     32'(if0.qn),         32'hFF);
    chk("rst_sticky", 32'(if0.err_sticky), 32'h0);
    chk("rst_inv",    32'(if0.invalid),    32'h0);
    #4 rst = 1'b1;
    drive(1'b1, SR, 8'h0F, 8'h00, 1'b0);
    tick();
    chk("sr_set_q",  32'(if0.q),  32'h0F);
    chk("sr_set_qn", 32'(if0.qn), 32'hF0);
    chk("sr_set_inv", 32'(if0.invalid), 32'h0);

    // 2. SR 1/1 under three policies
    drive(1'b1, DM, 8'hF0, 8'h00, 1'b0);
    tick();
    chk("d_load_f0", 32'(if0.q), 32'hF0);
    drive(1'b1, SR, 8'hFF, 8'h3C, 1'b0);
    tick();
    chk("sr11_p0_q", 32'(if0.q), 32'hF3);
    chk("sr11_p1_q", 32'(if1.q), 32'hFF);
    chk("sr11_p3_q", 32'(if3.q), 32'hCF);
    chk("sr11_inv",  32'(if0.invalid),    32'h1);
    chk("sr11_inv_p1", 32'(if1.invalid),  32'h1);
    chk("sr11_sticky", 32'(if0.err_sticky), 32'h1);
    drive(1'b1, SR, 8'h00, 8'h00, 1'b0);
    tick();
    chk("inv_pulse_end", 32'(if0.invalid),    32'h0);
    chk("sr_hold",       32'(if0.q),          32'hF3);
    chk("sticky_held",   32'(if0.err_sticky), 32'h1);

    // 3. JK, D, T, enable
    drive(1'b1, DM, 8'hAA, 8'h00, 1'b0);
    tick();
    drive(1'b1, JK, 8'hFF, 8'hFF, 1'b0);
    tick();
    chk("jk_toggle", 32'(if0.q), 32'h55);
    drive(1'b1, JK, 8'h0F, 8'hF0, 1'b0);
    tick();
    chk("jk_set_reset", 32'(if0.q), 32'h0F);
    drive(1'b1, DM, 8'h3C, 8'h00, 1'b0);
    tick();
    chk("d_3c", 32'(if0.q), 32'h3C);
    drive(1'b1, TM, 8'h0F, 8'h00, 1'b0);
    tick();
    chk("t_33", 32'(if0.q), 32'h33);
    drive(1'b0, TM, 8'hFF, 8'h00, 1'b0);
    tick();
    chk("en0_t", 32'(if0.q), 32'h33);
    drive(1'b0, DM, 8'h00, 8'h00, 1'b0);
    tick();
    chk("en0_d", 32'(if0.q), 32'h33);
    drive(1'b0, SR, 8'hFF, 8'hFF, 1'b0);
    tick();
    chk("en0_sr_q",   32'(if1.q),       32'h33);
    chk("en0_sr_inv", 32'(if0.invalid), 32'h0);

    // 4. clear vs. set priority on the sticky flag
    drive(1'b1, SR, 8'hFF, 8'hFF, 1'b1);
    tick();
    chk("clr_and_evt_sticky", 32'(if0.err_sticky), 32'h1);
    chk("clr_and_evt_q_p0",   32'(if0.q),          32'h33);
    chk("clr_and_evt_q_p3",   32'(if3.q),          32'hCC);
    drive(1'b1, SR, 8'h00, 8'h00, 1'b1);
    tick();
    chk("clr_alone_sticky", 32'(if0.err_sticky), 32'h0);
    drive(1'b1, SR, 8'h80, 8'h80, 1'b0);
    tick();
    chk("one_ch_sticky", 32'(if0.err_sticky), 32'h1);
    drive(1'b0, SR, 8'hFF, 8'hFF, 1'b1);
    tick();
    chk("clr_while_en0", 32'(if0.err_sticky), 32'h0);

    // 5. reset mid-cycle in T mode
    drive(1'b1, TM, 8'hFF, 8'h00, 1'b0);
    tick();
    chk("t_before_rst", 32'(if0.q), 32'hCC);
    #2 rst = 1'b0;
    #1;
    chk("midrst_q",  32'(if0.q),  32'h00);
    chk("midrst_qn", 32'(if0.qn), 32'hFF);
    #2 rst = 1'b1;
    tick();
    chk("t_after_rst", 32'(if0.q), 32'hFF);

`ifdef FF_BANK_ERRCNT_EN
    // 6. saturating event counter, 2 bits wide
    chk("cnt_after_rst", 32'(if0.err_cnt), 32'h0);
    drive(1'b1, SR, 8'h01, 8'h01, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("cnt_step%0d", i), 32'(if0.err_cnt), (i < 3) ? i + 1 : 3);
    end
    drive(1'b1, SR, 8'h00, 8'h00, 1'b1);
    tick();
    chk("cnt_clr", 32'(if0.err_cnt), 32'h0);
    drive(1'b1, SR, 8'hFF, 8'hFF, 1'b1);
    tick();
    chk("cnt_clr_and_evt", 32'(if0.err_cnt), 32'h1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: sim time exceeded, expected finish");
    $fatal(1);
  end
endmodule
